// File: rtl/inst_loader.sv
// inst_loader: assembles a little-endian byte stream into 32-bit words and writes them into instruction memory.
// Build option INST_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte that decides between done and error.
module inst_loader #(
  parameter int DEPTH      = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [5:0]                  len,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  output logic                        byte_ready,
  output logic                        mem_write_enable,
  output logic [$clog2(DEPTH)-1:0]    mem_addr,
  output logic [8*WORD_BYTES-1:0]     mem_write_data,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic                        cpu_run
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(WORD_BYTES);
  localparam int DW = 8 * WORD_BYTES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [AW-1:0]   word_cnt_q, word_cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   asm_q, asm_d;
  logic            ready_q, ready_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            run_q, run_d;
  logic            xfer;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
`endif

  assign xfer = byte_valid & ready_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef INST_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          if ((len == '0) || (len > LW'(DEPTH))) begin
            state_d = S_ERROR;
          end else begin
            state_d    = S_RECV;
            len_d      = len;
            word_cnt_d = '0;
            idx_d      = '0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_d      = '0;
`endif
          end
        end
      end
      S_RECV: begin
        if (xfer) begin
          asm_d[8*idx_q +: 8] = byte_data;
          idx_d = idx_q + 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d = sum_q + byte_data;
`endif
          if (idx_q == IW'(WORD_BYTES - 1)) begin
            state_d = S_WRITE;
            addr_d  = word_cnt_q;
            wdata_d = asm_d;
          end
        end
      end
      S_WRITE: begin
        // Counter holds on the last word so the address never wraps.
        if ({1'b0, word_cnt_q} == (len_q - 1'b1)) begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = S_RECV;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          state_d = (byte_data == sum_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    ready_d = (state_d == S_RECV) || (state_d == S_CHECK);
    we_d    = (state_d == S_WRITE);
    busy_d  = (state_d == S_RECV) || (state_d == S_WRITE) || (state_d == S_CHECK);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
    run_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      idx_q      <= '0;
      asm_q      <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      run_q      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      run_q      <= run_d;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign byte_ready       = ready_q;
  assign mem_write_enable = we_q;
  assign mem_addr         = addr_q;
  assign mem_write_data   = wdata_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign cpu_run          = run_q;

endmodule

// File: doc/inst_loader.md
# inst_loader

Instruction-memory loader: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into the 32-entry instruction memory. It is the write-side counterpart of the processor's PC-addressed instruction fetch. It holds the core stalled (`cpu_run` low) while a program is being loaded, then releases it.

## Interface
Parameters:
- `DEPTH`, 32: instruction memory words; address width is 5.
- `WORD_BYTES`, 4: bytes per instruction word; fixed at 4.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  one-cycle pulse that begins a load; sampled in IDLE, DONE and ERROR.
- `len`  in  6  number of words to load, valid range 1..32; sampled with `start`.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle; transfer occurs when `byte_valid & byte_ready`.
- `mem_write_enable`  out  1  instruction memory write strobe.
- `mem_addr`  out  5  write address.
- `mem_write_data`  out  32  write word.
- `busy`  out  1  a load is in progress.
- `done`  out  1  load completed successfully.
- `error`  out  1  load rejected or failed.
- `cpu_run`  out  1  core may fetch; low during reset, while loading, and after an error.

## Operation
- States: IDLE, RECV, WRITE, CHECK (macro only), DONE, ERROR. All outputs are registered.
- **IDLE:** `byte_ready` is 0.
  - `start` with `len` 0 or greater than 32 → ERROR.
  - `start` with a valid `len` → latch `len`, clear the word counter, byte index and checksum → RECV.
- **RECV:** `byte_ready` is 1.
  - Each accepted byte goes into byte lane `byte_idx`; the first byte fills bits 7:0, the fourth fills bits 31:24.
  - `byte_idx` increments and wraps 3→0.
  - Acceptance of the fourth byte → WRITE.
- **WRITE:** exactly one cycle.
  - `byte_ready` is 0, `mem_write_enable` is 1, `mem_addr` = word counter, `mem_write_data` = assembled word.
  - Then the word counter increments.
  - If this was word `len`-1 → DONE (or CHECK with the macro); else → RECV.
- **DONE:** `done` = 1 and `cpu_run` = 1, held until the next `start`.
- **ERROR:** `error` = 1 and `cpu_run` = 0, held until the next `start`.
- `start` in DONE or ERROR behaves as in IDLE: `done`, `error` and `cpu_run` drop in the cycle after `start`.
- `start` while `busy` (RECV, WRITE, CHECK) is ignored.
- `busy` is 1 in RECV, WRITE and CHECK.
- The word counter never exceeds `len`-1, so `mem_addr` never wraps. Bytes presented outside RECV or CHECK are not accepted.

## Timing
- Reset value of every output is 0: `byte_ready`, `mem_write_enable`, `mem_addr`, `mem_write_data`, `busy`, `done`, `error`, `cpu_run`.
- Reset mid-load returns to IDLE immediately. Words already written stay in memory and are not cleared.
- The `mem_write_enable` pulse is asserted in the cycle after the fourth byte handshake.
- Maximum throughput is 5 cycles per word: 4 byte cycles plus 1 write cycle.
- `byte_valid` may drop at any time; the partial word is retained indefinitely.
- `done` rises the cycle after the last WRITE (no macro), or after the checksum byte handshake (with the macro).
- A `start` with bad `len` produces `error` = 1 on the next cycle, with no memory writes.

## Configuration
- Macro: `INST_LOADER_CHECKSUM_EN`.
- **Defined:**
  - An 8-bit running sum (mod 256) of every accepted data byte is kept.
  - After the last WRITE, the FSM enters CHECK with `byte_ready` = 1 and accepts one extra byte.
  - Byte equal to the sum → DONE; otherwise → ERROR.
  - All data words are already written before the check.
- **Undefined:** no CHECK state and no sum register. The last WRITE goes straight to DONE.

## Test plan
- **Basic load:** `len` = 2; bytes 13 00 00 00 93 00 10 00 sent back-to-back → writes addr 0 = 0x00000013 and addr 1 = 0x00100093, two write pulses total, `done` = 1, `cpu_run` = 1.
- **Backpressure and gaps:** same stream with `byte_valid` deasserted for 3 cycles between every byte → identical writes, no extra or early write pulses, partial word intact.
- **Bad length:** `len` = 0 → `error` = 1 next cycle, no writes, `cpu_run` = 0. Repeat with `len` = 33 → same result. A following valid `start` clears `error`.
- **Reset mid-load:** assert `rst` after 2 bytes of word 0 → all outputs 0 asynchronously. Then a fresh 1-word load of 78 56 34 12 → addr 0 = 0x12345678.
- **Full depth:** `len` = 32 with word i = i → last write at addr 31 = 0x0000001F. No write to addr 0 after it, `done` = 1.
- **Checksum (macro defined):** basic load followed by checksum byte B6 → `done` = 1. The same load followed by B5 → `error` = 1, `cpu_run` = 0, both words still written.
